// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and types for the UART command-frame parser.
package uart_frame_pkg;

  localparam logic [7:0] SOF_B0 = 8'h55;
  localparam logic [7:0] SOF_B1 = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    SOF2,
    CMD,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload buffer: register file with synchronous write and combinational read.
module frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int AW      = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MAX_LEN];

  // Store one payload byte per write strobe; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA CMD LEN payload CHK frames from the UART byte stream and
// releases the payload on a valid/ready stream once the checksum matches.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN     = 16,
  parameter logic [15:0] TIMEOUT_CNT = 16'd8680
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_byte_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  // Checksum accumulation wraps modulo 256 by construction.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t        state_q, state_d;
  logic          done_d;
  logic          byte_stb;
  logic [7:0]    cmd_q, len_q, sum_q;
  logic [AW-1:0] idx_q, rd_idx_q;
  logic [15:0]   tmo_q;
  logic          ok_d, err_d;
  logic [1:0]    code_d;
  logic [7:0]    buf_rdata;
  logic          timed, expire, wr_last, rd_last;

  // rx_byte_done is a level; only its rising edge marks a new byte.
  assign byte_stb = rx_byte_done & ~done_d;
  assign timed    = (state_q == SOF2) || (state_q == CMD) || (state_q == LEN) ||
                    (state_q == PAYLOAD) || (state_q == CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign expire   = timed && !byte_stb && (tmo_q == TIMEOUT_CNT - 16'd1);
  assign wr_last  = (8'(idx_q) == len_q - 8'd1);
  assign rd_last  = (8'(rd_idx_q) == len_q - 8'd1);

  assign out_valid = (state_q == DRAIN) && (len_q != 8'd0);
  assign out_data  = out_valid ? buf_rdata : 8'd0;
  assign out_last  = out_valid && rd_last;

  frame_buf #(
    .MAX_LEN (MAX_LEN),
    .DATA_W  (8),
    .AW      (AW)
  ) u_buf (
    .clk   (sys_clk),
    .we    (byte_stb && (state_q == PAYLOAD)),
    .waddr (idx_q),
    .wdata (rx_data),
    .raddr (rd_idx_q),
    .rdata (buf_rdata)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the ok/error events registered below.
  always_comb begin
    state_d = state_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_CHK;
    if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
    end else begin
      case (state_q)
        IDLE:    if (byte_stb && rx_data == SOF_B0) state_d = SOF2;
        SOF2:    if (byte_stb) begin
                   if (rx_data == SOF_B1)      state_d = CMD;
                   else if (rx_data != SOF_B0) state_d = IDLE;
                 end
        CMD:     if (byte_stb) state_d = LEN;
        LEN:     if (byte_stb) begin
                   if (rx_data > MAX_LEN_B) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                     code_d  = ERR_LEN;
                   end else if (rx_data == 8'd0) begin
                     state_d = CHK;
                   end else begin
                     state_d = PAYLOAD;
                   end
                 end
        PAYLOAD: if (byte_stb && wr_last) state_d = CHK;
        CHK:     if (byte_stb) begin
                   if (rx_data == sum_q) begin
                     state_d = DRAIN;
                     ok_d    = 1'b1;
                   end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                     code_d  = ERR_CHK;
                   end
                 end
        DRAIN:   begin
                   // Bytes arriving while draining are dropped, never parsed.
                   if (byte_stb) begin
                     err_d  = 1'b1;
                     code_d = ERR_OVR;
                   end
                   if (len_q == 8'd0)                state_d = IDLE;
                   else if (out_ready && rd_last)    state_d = IDLE;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame header and running checksum; data only, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (byte_stb) begin
      case (state_q)
        CMD:     begin
                   cmd_q <= rx_data;
                   sum_q <= rx_data;
                 end
        LEN:     begin
                   len_q <= rx_data;
                   sum_q <= sum8(sum_q, rx_data);
                 end
        PAYLOAD: sum_q <= sum8(sum_q, rx_data);
        default: ;
      endcase
    end
  end

  // Control: edge detector, indices, gap timer and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      done_d    <= 1'b1;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      tmo_q     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_CHK;
      frame_cmd <= 8'd0;
      frame_len <= 8'd0;
    end else begin
      done_d    <= rx_byte_done;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      if (err_d) err_code <= code_d;
      if (ok_d) begin
        frame_cmd <= cmd_q;
        frame_len <= len_q;
      end
      tmo_q <= (byte_stb || !timed) ? '0 : tmo_q + 16'd1;
      if (byte_stb && state_q == LEN)          idx_q <= '0;
      else if (byte_stb && state_q == PAYLOAD) idx_q <= idx_q + IDX_ONE;
      if (state_q != DRAIN)                    rd_idx_q <= '0;
      else if (out_valid && out_ready)         rd_idx_q <= rd_idx_q + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed steps from the feature list plus random
// frames, all checked against a stream-level frame parser model.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int MAX = 16;
  localparam int TMO = 8680;
  localparam int HI  = 6;
  localparam int LO  = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [7:0] data = 8'd0;
  logic       out_valid, out_last, frame_ok, frame_err, out_ready;
  logic [7:0] out_data, frame_cmd, frame_len;
  logic [1:0] err_code;
  logic       rdy_mode = 1'b0, rdy_fix = 1'b1, rdy_rand = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stab_viol = 0;
  logic       hold_prev = 1'b0;
  logic [8:0] prev_beat = 9'd0;

  logic [15:0] got_ok[$], exp_ok[$];
  logic [1:0]  got_err[$], exp_err[$];
  logic [8:0]  got_out[$], exp_out[$];
  int          got_cyc[$];
  logic [7:0]  stim[$];

  assign out_ready = rdy_mode ? rdy_rand : rdy_fix;

  uart_frame_parser #(.MAX_LEN(MAX), .TIMEOUT_CNT(16'(TMO))) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .rx_byte_done (done),
    .rx_data      (data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_ok     (frame_ok),
    .frame_cmd    (frame_cmd),
    .frame_len    (frame_len),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  always #10 clk = ~clk;

  always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));

  // Record handshakes, ok/error pulses and stream stability at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (hold_prev && (!out_valid || {out_last, out_data} != prev_beat)) stab_viol++;
      if (out_valid && out_ready) begin
        got_out.push_back({out_last, out_data});
        got_cyc.push_back(cyc);
      end
      if (frame_ok)  got_ok.push_back({frame_cmd, frame_len});
      if (frame_err) got_err.push_back(err_code);
    end
    hold_prev = !rst && out_valid && !out_ready;
    prev_beat = {out_last, out_data};
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int low);
    data = b;
    done = 1'b1;
    repeat (HI) @(posedge clk);
    #1 done = 1'b0;
    repeat (low) @(posedge clk);
    #1;
  endtask

  // Send stim; byte li (if any) is followed by a custom low time ll.
  task automatic send_stim(input int li, input int ll);
    foreach (stim[i]) send_byte(stim[i], (i == li) ? ll : LO);
  endtask

  // Frame parser over the whole byte stream: a frame begins after a 55 AA pair
  // seen while hunting; a good frame yields ok + payload, else a coded error.
  task automatic model();
    int i = 0;
    int n = stim.size();
    int sum;
    int ln;
    logic armed = 1'b0;
    logic [7:0] cmd, b;
    while (i < n) begin
      b = stim[i];
      i++;
      if (!(armed && b == 8'hAA)) begin
        armed = (b == 8'h55);
        continue;
      end
      armed = 1'b0;
      if (i + 2 > n) break;
      cmd = stim[i];
      ln  = int'(stim[i+1]);
      i += 2;
      if (ln > MAX) begin
        exp_err.push_back(ERR_LEN);
        continue;
      end
      if (i + ln + 1 > n) break;
      sum = int'(cmd) + ln;
      for (int k = 0; k < ln; k++) sum += int'(stim[i+k]);
      if (sum % 256 == int'(stim[i+ln])) begin
        exp_ok.push_back({cmd, 8'(ln)});
        for (int k = 0; k < ln; k++) exp_out.push_back({(k == ln - 1), stim[i+k]});
      end else begin
        exp_err.push_back(ERR_CHK);
      end
      i += ln + 1;
    end
  endtask

  task automatic settle();
    int n = 0;
    while (out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_ok_count"}, 32'(got_ok.size()), 32'(exp_ok.size()));
    for (int i = 0; i < exp_ok.size() && i < got_ok.size(); i++)
      chk({tag, "_ok_cmd_len"}, 32'(got_ok[i]), 32'(exp_ok[i]));
    chk({tag, "_err_count"}, 32'(got_err.size()), 32'(exp_err.size()));
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
      chk({tag, "_err_code"}, 32'(got_err[i]), 32'(exp_err[i]));
    chk({tag, "_out_count"}, 32'(got_out.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      chk({tag, "_out_last_data"}, 32'(got_out[i]), 32'(exp_out[i]));
    got_ok.delete();  exp_ok.delete();
    got_err.delete(); exp_err.delete();
    got_out.delete(); exp_out.delete();
    got_cyc.delete();
  endtask

  initial begin
    int kind, nj, ln, s;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({out_valid, out_data, out_last, frame_ok, frame_cmd,
                              frame_len, frame_err, err_code}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good frame with consecutive payload beats
    stim = {8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_stim(-1, 0);
    model();
    settle();
    chk("good_consecutive", 32'(got_cyc.size() == 3 && got_cyc[1] == got_cyc[0] + 1 &&
                                got_cyc[2] == got_cyc[1] + 1), 32'd1);
    chk("good_frame_cmd", 32'(frame_cmd), 32'h10);
    chk("good_frame_len", 32'(frame_len), 32'h03);
    compare_all("good");

    // Empty payload, then checksum wrap
    stim = {8'h55, 8'hAA, 8'h80, 8'h00, 8'h80,
            8'h55, 8'hAA, 8'hFF, 8'h02, 8'hFF, 8'h03, 8'h03};
    send_stim(-1, 0);
    model();
    settle();
    compare_all("empty_wrap");

    // Bad checksum, then over-length, then a good frame proves return to idle
    stim = {8'h55, 8'hAA, 8'h10, 8'h01, 8'h05, 8'h00,
            8'h55, 8'hAA, 8'h10, 8'h11,
            8'h55, 8'hAA, 8'h07, 8'h01, 8'h09, 8'h11};
    send_stim(-1, 0);
    model();
    settle();
    compare_all("chk_len");

    // SOF resync and broken SOF
    stim = {8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'h01,
            8'h55, 8'h12, 8'hAA, 8'h01, 8'h00, 8'h01};
    send_stim(-1, 0);
    model();
    settle();
    compare_all("resync");

    // Byte exactly on the expiry cycle wins
    stim = {8'h55, 8'hAA, 8'h10, 8'h00, 8'h10};
    send_stim(2, TMO - HI);
    model();
    settle();
    compare_all("tmo_edge");

    // One cycle later the gap expires; trailing bytes are junk
    stim = {8'h55, 8'hAA, 8'h10, 8'h00, 8'h10};
    send_stim(2, TMO - HI + 1);
    exp_err.push_back(ERR_TMO);
    settle();
    chk("tmo_code_held", 32'(err_code), 32'(ERR_TMO));
    compare_all("tmo");

    // Backpressure with an overrun byte injected during drain
    rdy_fix = 1'b0;
    stim = {8'h55, 8'hAA, 8'h20, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0E};
    send_stim(-1, 0);
    model();
    repeat (200) @(posedge clk);
    #1;
    send_byte(8'h55, LO);
    exp_err.push_back(ERR_OVR);
    repeat (300) @(posedge clk);
    #1;
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_data_held", 32'(out_data), 32'hA1);
    rdy_fix = 1'b1;
    settle();
    chk("bp_stable", 32'(stab_viol), 32'd0);
    chk("ovr_code_held", 32'(err_code), 32'(ERR_OVR));
    compare_all("overrun");
    stim = {8'hAA, 8'h30, 8'h00, 8'h30};
    send_stim(-1, 0);
    model();
    settle();
    compare_all("no_hunt_dropped");

    // Reset mid-payload with a 0x55 level held across release
    stim = {8'h55, 8'hAA, 8'h40, 8'h05, 8'h11, 8'h22};
    send_stim(-1, 0);
    data = 8'h55;
    done = 1'b1;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", 32'({out_valid, out_data, out_last, frame_ok, frame_cmd,
                               frame_len, frame_err, err_code}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 done = 1'b0;
    repeat (LO) @(posedge clk);
    #1;
    stim = {8'hAA, 8'h01, 8'h00, 8'h01, 8'h55, 8'hAA, 8'h02, 8'h00, 8'h02};
    send_stim(-1, 0);
    model();
    settle();
    compare_all("after_reset");

    // Random frames with random backpressure
    rdy_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      stim.delete();
      kind = int'($urandom_range(0, 3));
      nj   = int'($urandom_range(0, 2));
      if (kind == 3) nj = nj + 1;
      for (int j = 0; j < nj; j++) begin
        do b = 8'($urandom); while (b == 8'h55);
        stim.push_back(b);
      end
      if (kind != 3) begin
        stim.push_back(8'h55);
        stim.push_back(8'hAA);
        b = 8'($urandom);
        stim.push_back(b);
        s = int'(b);
        if (kind == 2) begin
          stim.push_back(8'($urandom_range(MAX + 1, 255)));
        end else begin
          ln = int'($urandom_range(0, MAX));
          stim.push_back(8'(ln));
          s += ln;
          for (int j = 0; j < ln; j++) begin
            b = 8'($urandom);
            stim.push_back(b);
            s += int'(b);
          end
          if (kind == 1) s += int'($urandom_range(1, 255));
          stim.push_back(8'(s));
        end
      end
      send_stim(-1, 0);
      model();
      settle();
      compare_all("random");
    end
    rdy_mode = 1'b0;
    chk("random_stable", 32'(stab_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
